plot_sink_fb: RTL

//  Receiving end of the pixel-plot interface driven by the fillscreen/circle drawers
//  (x, y, colour, plot). Captures every plotted pixel into a 160x120x3 frame store.

---
 rtl/fb_pkg.sv | 31 +++
 rtl/fb_ram.sv | 44 ++++
 rtl/plot_sink_fb.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the plot-sink frame buffer.
//   - Frame geometry (160x120, 3-bit colour) and address width.
//   - Scan-out state encoding.
//   - fb_addr(): linear frame-store address of a pixel, y*160 + x,
//     built from two shifts and an add so no multiplier is inferred.
package fb_pkg;

    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 15;
    localparam int FB_DEPTH = 19200;

    localparam logic [7:0] H_RES  = 8'd160;
    localparam logic [6:0] V_RES  = 7'd120;
    localparam logic [7:0] X_LAST = 8'd159;
    localparam logic [6:0] Y_LAST = 7'd119;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    // y*160 + x == (y<<7) + (y<<5) + x
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        logic [ADDR_W-1:0] y_w;
        y_w = {8'd0, y};
        return (y_w << 7) + (y_w << 5) + {7'd0, x};
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Frame store: 19200 x COLOUR_W simple dual-port RAM.
//   clk    - clock, all activity on posedge
//   rst_n  - synchronous active-low reset (read data register only;
//            the array itself is never cleared)
//   we/waddr/wdata - write port
//   re/raddr       - read port, data on rdata one cycle after re
//   rdata          - registered read data; holds while re=0
// A read and write to the same address in one cycle returns the old
// contents because the array update and the read sample share an edge.
import fb_pkg::*;

module fb_ram (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [COLOUR_W-1:0] wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [COLOUR_W-1:0] rdata
);

    logic [COLOUR_W-1:0] mem_q [0:FB_DEPTH-1];
    logic [COLOUR_W-1:0] rdata_q;

    // Write port into the storage array
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port; the register holds its value when no read is issued
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= {COLOUR_W{1'b0}};
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/plot_sink_fb.sv
// Receiving end of the pixel-plot interface: captures plotted pixels into
// a 160x120x3 frame store and streams the frame out in raster order with a
// valid/ready handshake.
// Ports:
//   CLOCK_50, rst_n (synchronous, active-low)
//   plot, plot_x, plot_y, plot_colour - write strobe and pixel; out-of-range
//                                       coordinates are dropped
//   scan_start / scan_busy / scan_done - scan request and status
//   pix_x, pix_y, pix_colour, pix_valid, pix_ready - scan-out stream
//   plot_cnt, drop_cnt - accepted / dropped plot counters
// Build option: define PLOT_STATS_EN to enable the saturating plot
// counters; otherwise both counter outputs are tied to zero.
import fb_pkg::*;

module plot_sink_fb (
    input  logic                CLOCK_50,
    input  logic                rst_n,
    input  logic [7:0]          plot_x,
    input  logic [6:0]          plot_y,
    input  logic [COLOUR_W-1:0] plot_colour,
    input  logic                plot,
    input  logic                scan_start,
    output logic                scan_busy,
    output logic                scan_done,
    output logic [7:0]          pix_x,
    output logic [6:0]          pix_y,
    output logic [COLOUR_W-1:0] pix_colour,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [15:0]         plot_cnt,
    output logic [15:0]         drop_cnt
);

    scan_state_t       state_q;
    logic              scan_busy_q;
    logic              scan_done_q;
    logic              pix_valid_q;
    logic [7:0]        pix_x_q;
    logic [6:0]        pix_y_q;
    logic [7:0]        pix_x_d;
    logic [6:0]        pix_y_d;
    logic              hs_s;
    logic              last_s;
    logic              rd_en_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              wr_ok_s;

    assign wr_ok_s = plot && (plot_x < H_RES) && (plot_y < V_RES);

    // The RAM read register doubles as the pix_colour output register:
    // a new read is only issued once the presented pixel is accepted, so
    // the colour (and the coordinates below) hold steady during a stall.
    fb_ram u_ram (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .we    (wr_ok_s),
        .waddr (fb_addr(plot_x, plot_y)),
        .wdata (plot_colour),
        .re    (rd_en_s),
        .raddr (rd_addr_s),
        .rdata (pix_colour)
    );

    // Next raster position and read-issue decode
    always_comb begin
        hs_s   = pix_valid_q && pix_ready;
        last_s = (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);
        if (pix_x_q == X_LAST) begin
            pix_x_d = 8'd0;
            pix_y_d = pix_y_q + 7'd1;
        end else begin
            pix_x_d = pix_x_q + 8'd1;
            pix_y_d = pix_y_q;
        end
        rd_en_s   = 1'b0;
        rd_addr_s = {ADDR_W{1'b0}};
        case (state_q)
            FETCH: begin
                rd_en_s   = 1'b1;
                rd_addr_s = {ADDR_W{1'b0}};
            end
            STREAM: begin
                if (hs_s && !last_s) begin
                    rd_en_s   = 1'b1;
                    rd_addr_s = fb_addr(pix_x_d, pix_y_d);
                end else begin
                    rd_en_s   = 1'b0;
                end
            end
            default: begin
                rd_en_s = 1'b0;
            end
        endcase
    end

    // Scan FSM with its registered status and coordinate outputs
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= 8'd0;
            pix_y_q     <= 7'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    scan_done_q <= 1'b0;
                    if (scan_start) begin
                        state_q     <= FETCH;
                        scan_busy_q <= 1'b1;
                    end
                end
                FETCH: begin
                    state_q     <= STREAM;
                    pix_valid_q <= 1'b1;
                    pix_x_q     <= 8'd0;
                    pix_y_q     <= 7'd0;
                end
                STREAM: begin
                    if (hs_s) begin
                        if (last_s) begin
                            state_q     <= DONE;
                            pix_valid_q <= 1'b0;
                            scan_busy_q <= 1'b0;
                            scan_done_q <= 1'b1;
                        end else begin
                            pix_x_q <= pix_x_d;
                            pix_y_q <= pix_y_d;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    scan_done_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    scan_busy_q <= 1'b0;
                    scan_done_q <= 1'b0;
                    pix_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign scan_busy = scan_busy_q;
    assign scan_done = scan_done_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;

`ifdef PLOT_STATS_EN
    logic        drop_s;
    logic [15:0] plot_cnt_q;
    logic [15:0] drop_cnt_q;

    assign drop_s = plot && !wr_ok_s;

    // Saturating accepted/dropped plot counters
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            plot_cnt_q <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            if (wr_ok_s && (plot_cnt_q != 16'hFFFF)) begin
                plot_cnt_q <= plot_cnt_q + 16'd1;
            end
            if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign plot_cnt = plot_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign plot_cnt = 16'd0;
    assign drop_cnt = 16'd0;
`endif

endmodule
